axi_slave_mem: RTL and testbench
================================

AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, byte-address width.
REQ-002 SHALL provide parameter DATA_W, default 32, data width (fixed 4-byte beats, no size signals).
REQ-003 SHALL provide parameter ID_W, default 4, transaction ID width.
REQ-004 SHALL provide parameter MEM_DEPTH, default 256, number of DATA_W words in the internal array.
REQ-005 SHALL have the port aclk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have the port aresetn, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have the AW channel inputs awid[ID_W], awaddr[ADDR_W], awlen[8], awburst[2] and awvalid, plus the output awready.
REQ-008 SHALL have the W channel inputs wdata[DATA_W], wstrb[DATA_W/8], wlast and wvalid, plus the output wready.
REQ-009 SHALL have the B channel outputs bid[ID_W], bresp[2] and bvalid, plus the input bready.
REQ-010 SHALL have the AR channel inputs arid[ID_W], araddr[ADDR_W], arlen[8], arburst[2] and arvalid, plus the output arready.
REQ-011 SHALL have the R channel outputs rid[ID_W], rdata[DATA_W], rresp[2], rlast and rvalid, plus the input rready.

Function
REQ-012 SHALL be an AXI responder with exactly one outstanding transaction, using FSM states IDLE, WR_DATA, WR_RESP and RD_DATA.
REQ-013 SHALL, in IDLE, assert awready or arready (never both) for the selected channel only:
- When only one of awvalid/arvalid is set, that channel is selected.
- When both are set, round-robin against the last grant, with write preferred after reset.
REQ-014 SHALL, on an AW handshake, latch id/addr/len/burst, clear the beat counter and error accumulator, and go to WR_DATA.
REQ-015 SHALL, on an AR handshake, latch id/addr/len/burst and go to RD_DATA.
REQ-016 SHALL hold wready=1 throughout WR_DATA and accept one beat per cycle.
REQ-017 SHALL write each accepted W beat to the addressed word byte-wise under wstrb; bytes with wstrb=0 are unchanged.
REQ-018 SHALL leave WR_DATA after exactly awlen+1 beats regardless of wlast, deassert wready, and assert bvalid on the next cycle (WR_RESP).
REQ-019 SHALL hold bvalid/bid/bresp stable until bready, then return to IDLE on the cycle after the handshake.
REQ-020 SHALL assert rvalid in the cycle after the AR handshake, using registered rdata, with rlast=1 on beat arlen only.
REQ-021 SHALL hold rdata/rresp/rlast stable while rvalid=1 and rready=0, and present the next beat in the cycle after each R handshake.
REQ-022 SHALL deassert rvalid and return to IDLE after the final R handshake.
REQ-023 SHALL compute the word index as addr[ADDR_W-1:2]; low address bits are ignored, so accesses are always aligned.
REQ-024 SHALL compute beat addresses per burst type:
- FIXED (0): the same address every beat.
- INCR (1): +4 bytes per beat, with ADDR_W wrap-around.
- WRAP (2): +4 bytes per beat, wrapping within the aligned block of (len+1)*4 bytes.
REQ-025 SHALL treat burst=RESERVED (3), or WRAP with len not in {1,3,7,15}, as SLVERR:
- Every beat is still transferred.
- No memory write occurs.
- Read data is 0.
REQ-026 SHALL treat a beat with word index >= MEM_DEPTH as DECERR: the write is suppressed, or read data is 0.
REQ-027 SHALL treat wlast=1 before the final beat, or wlast=0 on the final beat, as a protocol error: bresp=SLVERR, while in-range data is still written.
REQ-028 SHALL set rresp per beat, and bresp to the worst beat response with priority DECERR(3) > SLVERR(2) > OKAY(0).
REQ-029 SHALL give reads a per-beat rresp, so mixed in-range and out-of-range INCR beats produce mixed rresp values.

Reset
REQ-030 SHALL, while aresetn=0, drive all of the following to 0:
- awready, wready, bvalid, arready, rvalid, rlast;
- bresp, rresp, bid, rid, rdata.
REQ-031 SHALL, while aresetn=0, set the FSM to IDLE and the grant pointer to write-preferred.
REQ-032 SHALL not clear memory contents on reset.
REQ-033 SHALL abort any in-flight burst on reset without issuing its B or R response.

Verification
REQ-034 INCR write id=3, addr 0x10, len=3, data 1..4, wstrb=F, then INCR read of the same region -> bresp=0, bid=3; rdata 1,2,3,4 with rlast on beat 4 and rvalid one cycle after the AR handshake.
REQ-035 WRAP write addr 0x18, len=3 -> words written at 0x18, 0x1C, 0x10, 0x14; WRAP with len=2 -> bresp=2 and memory unchanged.
REQ-036 awvalid and arvalid asserted in the same cycle, twice in succession -> write granted first, then read; rready toggled 0/1 during the read -> rdata held stable while stalled.
REQ-037 INCR read addr 0x3F8, len=3 (MEM_DEPTH=256) -> rresp 0,0,3,3 with out-of-range data 0; write with wstrb=0x3 -> only the low 2 bytes change.
REQ-038 Early wlast on beat 1 of a len=2 write -> all 3 beats accepted and bresp=2; aresetn pulsed mid-read -> rvalid=0, state IDLE, and memory contents retained.

Source files
------------

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI memory responder that handles one transaction at a time,
// backed by an internal word array of MEM_DEPTH x DATA_W.
// Ports:
//   aclk, aresetn                         clock, async active-low reset
//   aw*  (awid/awaddr/awlen/awburst/awvalid -> awready)  write address channel
//   w*   (wdata/wstrb/wlast/wvalid -> wready)            write data channel
//   b*   (bid/bresp/bvalid <- bready)                    write response channel
//   ar*  (arid/araddr/arlen/arburst/arvalid -> arready)  read address channel
//   r*   (rid/rdata/rresp/rlast/rvalid <- rready)        read data channel
// Beats are fixed at 4 bytes. The low two address bits are ignored.
// Bad bursts give SLVERR, words past MEM_DEPTH give DECERR. A wlast that does
// not line up with the final beat also gives SLVERR.
module axi_slave_mem #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 256
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_DATA = 2'd1;
  localparam logic [1:0] ST_WR_RESP = 2'd2;
  localparam logic [1:0] ST_RD_DATA = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  logic [1:0]        r_state;
  logic              r_prio_wr;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [1:0]        r_burst;
  logic [1:0]        r_err;
  logic              r_rvalid;
  logic              r_rlast;
  logic [1:0]        r_rresp;
  logic [DATA_W-1:0] r_rdata;

  logic              w_aw_hs;
  logic              w_ar_hs;
  logic [ADDR_W-1:0] w_next_addr;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [1:0]        w_wr_resp;
  logic [1:0]        w_beat_resp;
  logic              w_wr_last;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [1:0]        w_rd_resp;
  logic [DATA_W-1:0] w_rd_data;

  function automatic logic [1:0] beat_resp(input logic [IDX_W-1:0] idx,
                                           input logic [7:0] len,
                                           input logic [1:0] burst);
    logic bad_burst;
    bad_burst = (burst == 2'd3) ||
                ((burst == BURST_WRAP) &&
                 !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
    if (32'(idx) >= MEM_DEPTH) return RESP_DECERR;
    if (bad_burst)             return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0] len,
                                                  input logic [1:0] burst);
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] mask;
    inc  = addr + ADDR_W'(4);
    // (len+1)*4-1, the byte mask of the wrap block for legal WRAP lengths
    mask = ADDR_W'({len, 2'b11});
    case (burst)
      BURST_FIXED: return addr;
      BURST_WRAP:  return (addr & ~mask) | (inc & mask);
      default:     return inc;
    endcase
  endfunction

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    awready = 1'b0;
    arready = 1'b0;
    if (aresetn && (r_state == ST_IDLE)) begin
      // r_prio_wr: the previous grant went to read (or reset), so write wins a tie
      awready = awvalid & (~arvalid | r_prio_wr);
      arready = arvalid & (~awvalid | ~r_prio_wr);
    end
  end

  always_comb begin
    w_aw_hs     = awvalid & awready;
    w_ar_hs     = arvalid & arready;
    w_next_addr = next_addr(r_addr, r_len, r_burst);
    w_wr_idx    = r_addr[ADDR_W-1:2];
    w_wr_resp   = beat_resp(w_wr_idx, r_len, r_burst);
    w_wr_last   = (r_cnt == r_len);
    w_beat_resp = worst(w_wr_resp, (wlast != w_wr_last) ? RESP_SLVERR : RESP_OKAY);
    w_mem_we    = (r_state == ST_WR_DATA) & wvalid & (w_wr_resp == RESP_OKAY);
    if (r_state == ST_RD_DATA) begin
      w_rd_idx  = w_next_addr[ADDR_W-1:2];
      w_rd_resp = beat_resp(w_rd_idx, r_len, r_burst);
    end else begin
      w_rd_idx  = araddr[ADDR_W-1:2];
      w_rd_resp = beat_resp(w_rd_idx, arlen, arburst);
    end
    w_rd_data = (w_rd_resp == RESP_OKAY) ? r_mem[w_rd_idx[MEM_AW-1:0]] : '0;
  end

  always_ff @(posedge aclk) begin
    if (w_mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) r_mem[w_wr_idx[MEM_AW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_prio_wr <= 1'b1;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= '0;
      r_err     <= '0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs) begin
            r_id      <= awid;
            r_addr    <= awaddr;
            r_len     <= awlen;
            r_burst   <= awburst;
            r_cnt     <= '0;
            r_err     <= RESP_OKAY;
            r_prio_wr <= 1'b0;
            r_state   <= ST_WR_DATA;
          end else if (w_ar_hs) begin
            r_id      <= arid;
            r_addr    <= araddr;
            r_len     <= arlen;
            r_burst   <= arburst;
            r_cnt     <= '0;
            r_prio_wr <= 1'b1;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_resp;
            r_rlast   <= (arlen == 8'd0);
            r_state   <= ST_RD_DATA;
          end
        end
        ST_WR_DATA: begin
          if (wvalid) begin
            r_err  <= worst(r_err, w_beat_resp);
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 8'd1;
            if (w_wr_last) r_state <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bready) r_state <= ST_IDLE;
        end
        default: begin
          if (rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= ST_IDLE;
            end else begin
              r_addr  <= w_next_addr;
              r_cnt   <= r_cnt + 8'd1;
              r_rdata <= w_rd_data;
              r_rresp <= w_rd_resp;
              r_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    wready = (r_state == ST_WR_DATA);
    bvalid = (r_state == ST_WR_RESP);
    bid    = r_id;
    bresp  = r_err;
    rid    = r_id;
    rdata  = r_rdata;
    rresp  = r_rresp;
    rlast  = r_rlast;
    rvalid = r_rvalid;
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed bench for axi_slave_mem with a table of bursts
// and hand-written sequences for arbitration, stalls and reset abort.
module tb_axi_slave_mem;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [15:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int n_vec = 0;
  int n_bad = 0;

  axi_slave_mem #(
    .ADDR_W(16),
    .DATA_W(32),
    .ID_W(4),
    .MEM_DEPTH(256)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] base;
    logic [7:0]  wl;
    logic [1:0]  bresp;
    logic [31:0] ed [4];
    logic [1:0]  er [4];
  } vec_t;

  function automatic vec_t mkw(input logic [3:0] id, input logic [15:0] a,
                               input logic [7:0] len, input logic [1:0] bu,
                               input logic [3:0] s, input logic [31:0] base,
                               input logic [7:0] wl, input logic [1:0] resp);
    vec_t v;
    v.wr = 1'b1; v.id = id; v.addr = a; v.len = len; v.burst = bu;
    v.strb = s; v.base = base; v.wl = wl; v.bresp = resp;
    for (int i = 0; i < 4; i++) begin v.ed[i] = '0; v.er[i] = '0; end
    return v;
  endfunction

  function automatic vec_t mkr(input logic [3:0] id, input logic [15:0] a,
                               input logic [7:0] len, input logic [1:0] bu,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3,
                               input logic [1:0] r0, input logic [1:0] r1,
                               input logic [1:0] r2, input logic [1:0] r3);
    vec_t v;
    v.wr = 1'b0; v.id = id; v.addr = a; v.len = len; v.burst = bu;
    v.strb = '0; v.base = '0; v.wl = '0; v.bresp = '0;
    v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2; v.ed[3] = d3;
    v.er[0] = r0; v.er[1] = r1; v.er[2] = r2; v.er[3] = r3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_aw(input vec_t v);
    awid = v.id; awaddr = v.addr; awlen = v.len; awburst = v.burst; awvalid = 1'b1;
  endtask

  task automatic set_ar(input vec_t v);
    arid = v.id; araddr = v.addr; arlen = v.len; arburst = v.burst; arvalid = 1'b1;
  endtask

  task automatic aw_hs(input vec_t v);
    int k = 0;
    @(negedge aclk);
    set_aw(v);
    #1;
    while (!awready && k < 20) begin @(negedge aclk); #1; k++; end
    chk("awready", 32'(awready), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0;
    #1;
  endtask

  task automatic ar_hs(input vec_t v);
    int k = 0;
    @(negedge aclk);
    set_ar(v);
    #1;
    while (!arready && k < 20) begin @(negedge aclk); #1; k++; end
    chk("arready", 32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    #1;
    chk("rvalid_latency", 32'(rvalid), 32'd1);
  endtask

  task automatic w_phase(input vec_t v, input string tag);
    for (int i = 0; i <= int'(v.len); i++) begin
      @(negedge aclk);
      wdata  = v.base + 32'(i);
      wstrb  = v.strb;
      wlast  = (i == int'(v.wl));
      wvalid = 1'b1;
      if (i == 0) begin #1; chk({tag, " wready"}, 32'(wready), 32'd1); end
    end
    @(negedge aclk);
    wvalid = 1'b0;
    wlast  = 1'b0;
    #1;
    chk({tag, " wready_done"}, 32'(wready), 32'd0);
    chk({tag, " bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, " bid"}, 32'(bid), 32'(v.id));
    chk({tag, " bresp"}, 32'(bresp), 32'(v.bresp));
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    #1;
    chk({tag, " bvalid_clr"}, 32'(bvalid), 32'd0);
  endtask

  task automatic r_phase(input vec_t v, input bit stall, input string tag);
    for (int i = 0; i <= int'(v.len); i++) begin
      @(negedge aclk);
      rready = 1'b0;
      #1;
      chk($sformatf("%s b%0d rvalid", tag, i), 32'(rvalid), 32'd1);
      chk($sformatf("%s b%0d rdata", tag, i), rdata, v.ed[i]);
      chk($sformatf("%s b%0d rresp", tag, i), 32'(rresp), 32'(v.er[i]));
      chk($sformatf("%s b%0d rlast", tag, i), 32'(rlast), (i == int'(v.len)) ? 32'd1 : 32'd0);
      if (i == 0) chk({tag, " rid"}, 32'(rid), 32'(v.id));
      if (stall) begin
        @(negedge aclk);
        #1;
        chk($sformatf("%s b%0d rdata_hold", tag, i), rdata, v.ed[i]);
        chk($sformatf("%s b%0d rlast_hold", tag, i), 32'(rlast), (i == int'(v.len)) ? 32'd1 : 32'd0);
      end
      rready = 1'b1;
    end
    @(negedge aclk);
    rready = 1'b0;
    #1;
    chk({tag, " rvalid_clr"}, 32'(rvalid), 32'd0);
  endtask

  vec_t vt[$];
  vec_t v;

  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b1;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b1; rready = 1'b0;

    // Table: writes check bresp; reads check every beat.
    vt.push_back(mkw(4'd1, 16'h0018, 8'd3, 2'd2, 4'hF, 32'h100, 8'd3, 2'd0));
    vt.push_back(mkr(4'd2, 16'h0010, 8'd3, 2'd1, 32'h102, 32'h103, 32'h100, 32'h101, 0, 0, 0, 0));
    vt.push_back(mkr(4'd4, 16'h001C, 8'd3, 2'd2, 32'h101, 32'h102, 32'h103, 32'h100, 0, 0, 0, 0));
    vt.push_back(mkr(4'd4, 16'h0012, 8'd1, 2'd1, 32'h102, 32'h103, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkw(4'd9, 16'h0010, 8'd2, 2'd2, 4'hF, 32'hDEAD0000, 8'd2, 2'd2));
    vt.push_back(mkr(4'd2, 16'h0010, 8'd3, 2'd1, 32'h102, 32'h103, 32'h100, 32'h101, 0, 0, 0, 0));
    vt.push_back(mkr(4'd3, 16'h0010, 8'd2, 2'd2, 0, 0, 0, 0, 2, 2, 2, 0));
    vt.push_back(mkw(4'd2, 16'h0040, 8'd1, 2'd0, 4'hF, 32'hA0, 8'd1, 2'd0));
    vt.push_back(mkr(4'd2, 16'h0040, 8'd1, 2'd0, 32'hA1, 32'hA1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkw(4'd5, 16'h0040, 8'd0, 2'd3, 4'hF, 32'hFF, 8'd0, 2'd2));
    vt.push_back(mkr(4'd5, 16'h0040, 8'd0, 2'd1, 32'hA1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkw(4'd6, 16'h03F8, 8'd3, 2'd1, 4'hF, 32'h50, 8'd3, 2'd3));
    vt.push_back(mkr(4'd6, 16'h03F8, 8'd3, 2'd1, 32'h50, 32'h51, 0, 0, 0, 0, 3, 3));
    vt.push_back(mkw(4'd7, 16'h0044, 8'd0, 2'd1, 4'hF, 32'hAABBCCDD, 8'd0, 2'd0));
    vt.push_back(mkw(4'd7, 16'h0044, 8'd0, 2'd1, 4'h3, 32'h11223344, 8'd0, 2'd0));
    vt.push_back(mkr(4'd7, 16'h0044, 8'd0, 2'd1, 32'hAABB3344, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkw(4'd8, 16'h0080, 8'd2, 2'd1, 4'hF, 32'h70, 8'd1, 2'd2));
    vt.push_back(mkr(4'd8, 16'h0080, 8'd2, 2'd1, 32'h70, 32'h71, 32'h72, 0, 0, 0, 0, 0));
    vt.push_back(mkw(4'd9, 16'h0090, 8'd1, 2'd1, 4'hF, 32'h200, 8'd255, 2'd2));
    vt.push_back(mkr(4'd9, 16'h0090, 8'd1, 2'd1, 32'h200, 32'h201, 0, 0, 0, 0, 0, 0));
    vt.push_back(mkw(4'd10, 16'hFFFC, 8'd1, 2'd1, 4'hF, 32'h300, 8'd1, 2'd3));
    vt.push_back(mkr(4'd10, 16'hFFFC, 8'd1, 2'd1, 0, 32'h301, 0, 0, 3, 0, 0, 0));

    // Reset state, with both address valids asserted to confirm readies stay low
    repeat (2) @(negedge aclk);
    #1;
    chk("rst awready", 32'(awready), 32'd0);
    chk("rst arready", 32'(arready), 32'd0);
    chk("rst wready", 32'(wready), 32'd0);
    chk("rst bvalid", 32'(bvalid), 32'd0);
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst rlast", 32'(rlast), 32'd0);
    chk("rst bresp", 32'(bresp), 32'd0);
    chk("rst rresp", 32'(rresp), 32'd0);
    chk("rst bid", 32'(bid), 32'd0);
    chk("rst rid", 32'(rid), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    awvalid = 1'b0;
    arvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;

    // Simultaneous AW/AR twice: write first after reset, then read
    @(negedge aclk);
    set_aw(mkw(4'd3, 16'h0010, 8'd3, 2'd1, 4'hF, 32'd1, 8'd3, 2'd0));
    set_ar(mkr(4'd5, 16'h0010, 8'd3, 2'd1, 1, 2, 3, 4, 0, 0, 0, 0));
    #1;
    chk("tie1 awready", 32'(awready), 32'd1);
    chk("tie1 arready", 32'(arready), 32'd0);
    @(negedge aclk);
    awvalid = 1'b0;
    arvalid = 1'b0;
    w_phase(mkw(4'd3, 16'h0010, 8'd3, 2'd1, 4'hF, 32'd1, 8'd3, 2'd0), "incr_wr");
    @(negedge aclk);
    set_aw(mkw(4'd3, 16'h0020, 8'd0, 2'd1, 4'hF, 32'd0, 8'd0, 2'd0));
    set_ar(mkr(4'd5, 16'h0010, 8'd3, 2'd1, 1, 2, 3, 4, 0, 0, 0, 0));
    #1;
    chk("tie2 awready", 32'(awready), 32'd0);
    chk("tie2 arready", 32'(arready), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0;
    arvalid = 1'b0;
    #1;
    chk("tie2 rvalid_latency", 32'(rvalid), 32'd1);
    r_phase(mkr(4'd5, 16'h0010, 8'd3, 2'd1, 1, 2, 3, 4, 0, 0, 0, 0), 1'b1, "incr_rd");

    foreach (vt[i]) begin
      v = vt[i];
      if (v.wr) begin
        aw_hs(v);
        w_phase(v, $sformatf("v%0d", i));
      end else begin
        ar_hs(v);
        r_phase(v, (i % 3) == 0, $sformatf("v%0d", i));
      end
    end

    // Reset in the middle of a read burst
    ar_hs(mkr(4'd11, 16'h0010, 8'd3, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge aclk);
    rready = 1'b1;
    #1;
    chk("abort_rd b0 rdata", rdata, 32'h102);
    @(negedge aclk);
    rready = 1'b0;
    #1;
    chk("abort_rd b1 rdata", rdata, 32'h103);
    aresetn = 1'b0;
    #1;
    chk("abort_rd rvalid", 32'(rvalid), 32'd0);
    chk("abort_rd rlast", 32'(rlast), 32'd0);
    chk("abort_rd rdata", rdata, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Reset after an AW handshake: no B response, grant pointer back to write
    aw_hs(mkw(4'd12, 16'h0060, 8'd3, 2'd1, 4'hF, 32'h900, 8'd3, 2'd0));
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    chk("abort_wr wready", 32'(wready), 32'd0);
    chk("abort_wr bvalid", 32'(bvalid), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    #1;
    chk("abort_wr no_b", 32'(bvalid), 32'd0);
    @(negedge aclk);
    set_aw(mkw(4'd13, 16'h0060, 8'd0, 2'd1, 4'hF, 32'h555, 8'd0, 2'd0));
    set_ar(mkr(4'd13, 16'h0010, 8'd0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rst_tie awready", 32'(awready), 32'd1);
    chk("rst_tie arready", 32'(arready), 32'd0);
    @(negedge aclk);
    awvalid = 1'b0;
    arvalid = 1'b0;
    w_phase(mkw(4'd13, 16'h0060, 8'd0, 2'd1, 4'hF, 32'h555, 8'd0, 2'd0), "rst_tie_wr");

    // Memory survives reset
    v = mkr(4'd14, 16'h0010, 8'd3, 2'd1, 32'h102, 32'h103, 32'h100, 32'h101, 0, 0, 0, 0);
    ar_hs(v);
    r_phase(v, 1'b0, "retain");
    v = mkr(4'd14, 16'h0060, 8'd0, 2'd1, 32'h555, 0, 0, 0, 0, 0, 0, 0);
    ar_hs(v);
    r_phase(v, 1'b0, "post_rst_wr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
